// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: synchronizes ir_in, times its edges and decodes 32-bit frames into cmd/addr plus play/stop levels.
// Optional repeat-code strobe enabled by defining IR_REPEAT_EN.
module ir_nec_decoder #(
    parameter int         UNIT_CYCLES = 28125,
    parameter logic [7:0] KEY_PLAY    = 8'h43,
    parameter logic [7:0] KEY_STOP    = 8'h40
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ir_in,
    output logic [7:0] cmd,
    output logic [7:0] addr,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       play_pause,
    output logic       stop,
    output logic       repeat_valid
);
    localparam int U  = UNIT_CYCLES;
    localparam int TO = 24 * U;
    localparam int CW = $clog2(TO) + 1;
    localparam int DW = CW + 1;

    localparam logic [CW-1:0] TO_C  = CW'(TO);
    localparam logic [DW-1:0] M_LO  = DW'(U / 2);
    localparam logic [DW-1:0] M_HI  = DW'((3 * U) / 2 - 1);
    localparam logic [DW-1:0] LM_LO = DW'(12 * U);
    localparam logic [DW-1:0] LM_HI = DW'(20 * U);
    localparam logic [DW-1:0] LS_LO = DW'(6 * U);
    localparam logic [DW-1:0] LS_HI = DW'(10 * U);
    localparam logic [DW-1:0] RP_LO = DW'(3 * U);
    localparam logic [DW-1:0] RP_HI = DW'(5 * U);
    localparam logic [DW-1:0] B0_HI = DW'(2 * U - 1);
    localparam logic [DW-1:0] B1_LO = DW'(2 * U);
    localparam logic [DW-1:0] B1_HI = DW'(4 * U);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, END_MARK
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dur;
    logic [31:0]   shreg;
    logic [4:0]    bit_idx;
    logic          rise, fall, edge_seen, timeout, frame_ok;
`ifdef IR_REPEAT_EN
    logic          rpt, have_frame;
`endif

    function automatic logic win(input logic [DW-1:0] d, input logic [DW-1:0] lo,
                                 input logic [DW-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign edge_seen = rise | fall;
    // Duration equals the cycle spacing between two synchronized edges.
    assign dur       = {1'b0, cnt} + DW'(1);
    assign timeout   = (state != IDLE) && (cnt == TO_C);
    assign frame_ok  = ((shreg[7:0] ^ shreg[15:8]) == 8'hFF) &&
                       ((shreg[23:16] ^ shreg[31:24]) == 8'hFF);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            s3  <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= ir_in;
            s2 <= s1;
            s3 <= s2;
            if (edge_seen)
                cnt <= '0;
            else if (cnt != TO_C)
                cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            cmd        <= '0;
            addr       <= '0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            play_pause <= 1'b0;
            stop       <= 1'b0;
`ifdef IR_REPEAT_EN
            repeat_valid <= 1'b0;
            rpt          <= 1'b0;
            have_frame   <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef IR_REPEAT_EN
            repeat_valid <= 1'b0;
`endif
            if (timeout) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else if (edge_seen) begin
                case (state)
                    IDLE: if (fall) state <= LEAD_MARK;
                    LEAD_MARK: begin
                        if (win(dur, LM_LO, LM_HI)) state <= LEAD_SPACE;
                        else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    LEAD_SPACE: begin
                        if (win(dur, LS_LO, LS_HI)) begin
                            state   <= BIT_MARK;
                            bit_idx <= '0;
`ifdef IR_REPEAT_EN
                            rpt     <= 1'b0;
`endif
                        end else if (win(dur, RP_LO, RP_HI)) begin
`ifdef IR_REPEAT_EN
                            state <= END_MARK;
                            rpt   <= 1'b1;
`else
                            state <= IDLE;
`endif
                        end else begin
                            // Falling edge may be the start of a fresh leader.
                            frame_err <= 1'b1;
                            state     <= LEAD_MARK;
                        end
                    end
                    BIT_MARK: begin
                        if (win(dur, M_LO, M_HI)) state <= BIT_SPACE;
                        else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    BIT_SPACE: begin
                        if (win(dur, M_LO, B0_HI) || win(dur, B1_LO, B1_HI)) begin
                            shreg   <= {win(dur, B1_LO, B1_HI), shreg[31:1]};
                            bit_idx <= bit_idx + 5'd1;
                            state   <= (bit_idx == 5'd31) ? END_MARK : BIT_MARK;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= LEAD_MARK;
                        end
                    end
                    END_MARK: begin
                        state <= IDLE;
                        if (!win(dur, M_LO, M_HI))
                            frame_err <= 1'b1;
`ifdef IR_REPEAT_EN
                        else if (rpt) begin
                            if (have_frame) repeat_valid <= 1'b1;
                            else            frame_err    <= 1'b1;
                        end
`endif
                        else if (frame_ok) begin
                            cmd       <= shreg[23:16];
                            addr      <= shreg[7:0];
                            cmd_valid <= 1'b1;
`ifdef IR_REPEAT_EN
                            have_frame <= 1'b1;
`endif
                        end else
                            frame_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end

            // Key levels follow the freshly latched command one cycle after cmd_valid.
            if (cmd_valid) begin
                if (cmd == KEY_PLAY) begin
                    stop       <= 1'b0;
                    play_pause <= stop ? 1'b1 : ~play_pause;
                end else if (cmd == KEY_STOP) begin
                    stop       <= 1'b1;
                    play_pause <= 1'b0;
                end
            end
        end
    end

`ifndef IR_REPEAT_EN
    assign repeat_valid = 1'b0;
`endif
endmodule
